// File: rtl/sensor_clock_controller.sv
// -----------------------------------------------------------------------------
// sensor_clock_controller
//
// Runtime controller for the camera sensor master clock (XCLK). It produces
// output_clock as a registered divide of input_clock. The half-period is
// programmable at runtime through a valid/ready config handshake. Start, stop
// and divisor changes take effect only at clean phase boundaries, so the
// sensor never sees a runt pulse.
//
// Ports:
//   input_clock      sole clock
//   reset            synchronous, active-high
//   enable           level: 1 = run output clock, 0 = stop at next fall
//   cfg_half_period  requested half-period in input_clock cycles (0 -> 1)
//   cfg_valid        config request
//   cfg_ready        config can be accepted (nothing pending)
//   output_clock     divided sensor clock, registered
//   rise_strobe      high in the first cycle output_clock is 1
//   fall_strobe      high in the first cycle output_clock is 0 again
//   running          state is RUN or STOPPING
//   stable           STARTUP_PERIODS rising edges seen since last start/apply
//
// Optional feature (macro SENSOR_CLOCK_PERIOD_COUNT_EN):
//   adds period_count[31:0], a free-running count of rising edges that
//   wraps and is cleared only by reset.
// -----------------------------------------------------------------------------
module sensor_clock_controller #(
   parameter int COUNTER_WIDTH       = 8,
   parameter int DEFAULT_HALF_PERIOD = 2,
   parameter int STARTUP_PERIODS     = 16
) (
   input  logic                     input_clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [COUNTER_WIDTH-1:0] cfg_half_period,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   output logic                     output_clock,
   output logic                     rise_strobe,
   output logic                     fall_strobe,
   output logic                     running,
   output logic                     stable
`ifdef SENSOR_CLOCK_PERIOD_COUNT_EN
   ,output logic [31:0]             period_count
`endif
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_RUN      = 2'd1;
   localparam logic [1:0] ST_STOPPING = 2'd2;

   localparam int STARTUP_W = $clog2(STARTUP_PERIODS + 1);

   localparam logic [COUNTER_WIDTH-1:0] ONE          = COUNTER_WIDTH'(1);
   localparam logic [COUNTER_WIDTH-1:0] ZERO         = '0;
   localparam logic [COUNTER_WIDTH-1:0] DEFAULT_HALF = COUNTER_WIDTH'(DEFAULT_HALF_PERIOD);
   localparam logic [STARTUP_W-1:0]     STARTUP_DONE = STARTUP_W'(STARTUP_PERIODS);

   logic [1:0]               state;
   logic [1:0]               next_state;
   logic [COUNTER_WIDTH-1:0] counter;
   logic [COUNTER_WIDTH-1:0] half_period;
   logic [COUNTER_WIDTH-1:0] pending_half;
   logic                     pending;
   logic [STARTUP_W-1:0]     startup_count;

   logic active;
   logic phase_end;
   logic rise_edge;
   logic fall_edge;
   logic accept;
   logic apply_now;

   // Boundary decode: phase_end marks the edge at which output_clock toggles.
   assign active    = (state == ST_RUN) || (state == ST_STOPPING);
   assign phase_end = active && (counter == (half_period - ONE));
   assign rise_edge = phase_end && !output_clock;
   assign fall_edge = phase_end &&  output_clock;

   // Handshake. accept and apply_now are mutually exclusive because accept
   // needs pending low and apply needs it high, so a config accepted on a
   // fall boundary waits for the following one.
   assign cfg_ready = !pending;
   assign accept    = cfg_valid && cfg_ready;
   assign apply_now = pending && ((state == ST_IDLE) || fall_edge);

   assign running   = active;
   assign stable    = (startup_count == STARTUP_DONE);

   // Re-asserting enable while STOPPING returns to RUN without touching the
   // counter or phase, so an aborted stop is invisible on the output.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:     if (enable) next_state = ST_RUN;
         ST_RUN:      if (!enable) next_state = ST_STOPPING;
         ST_STOPPING: begin
            if (enable)         next_state = ST_RUN;
            else if (fall_edge) next_state = ST_IDLE;
         end
         default:     next_state = ST_IDLE;
      endcase
   end

   // Control and divider state.
   always_ff @(posedge input_clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         counter      <= ZERO;
         output_clock <= 1'b0;
         rise_strobe  <= 1'b0;
         fall_strobe  <= 1'b0;
      end else begin
         state       <= next_state;
         rise_strobe <= rise_edge;
         fall_strobe <= fall_edge;
         if (next_state == ST_IDLE) begin
            // Entering or staying idle always parks the output low.
            output_clock <= 1'b0;
            counter      <= ZERO;
         end else if (phase_end) begin
            output_clock <= !output_clock;
            counter      <= ZERO;
         end else if (active) begin
            counter <= counter + ONE;
         end else begin
            // IDLE -> RUN: first rise lands half_period cycles later.
            counter <= ZERO;
         end
      end
   end

   // Config capture and apply.
   always_ff @(posedge input_clock) begin
      if (reset) begin
         pending     <= 1'b0;
         half_period <= DEFAULT_HALF;
      end else if (accept) begin
         pending <= 1'b1;
      end else if (apply_now) begin
         pending     <= 1'b0;
         half_period <= pending_half;
      end
   end

   // Requested value held until apply; a zero request means divide-by-2.
   always_ff @(posedge input_clock) begin
      if (accept) begin
         pending_half <= (cfg_half_period == ZERO) ? ONE : cfg_half_period;
      end
   end

   // Startup qualification: rising edges seen in RUN, saturating.
   always_ff @(posedge input_clock) begin
      if (reset) begin
         startup_count <= '0;
      end else if ((next_state == ST_IDLE) || apply_now) begin
         startup_count <= '0;
      end else if ((state == ST_RUN) && rise_edge && (startup_count != STARTUP_DONE)) begin
         startup_count <= startup_count + STARTUP_W'(1);
      end
   end

`ifdef SENSOR_CLOCK_PERIOD_COUNT_EN
   // Lifetime rising-edge count; survives stop and apply, wraps naturally.
   always_ff @(posedge input_clock) begin
      if (reset) begin
         period_count <= 32'd0;
      end else if (rise_edge) begin
         period_count <= period_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sensor_clock_controller.sv
// -----------------------------------------------------------------------------
// tb_sensor_clock_controller
//
// Directed bench for sensor_clock_controller: default divide, reconfig while
// running, zero config, clean stop, stop abort, back-to-back config and reset
// mid-run. Expected values are written out by hand per cycle.
// -----------------------------------------------------------------------------
module tb_sensor_clock_controller;

   localparam int CW = 8;

   logic          input_clock = 1'b0;
   logic          reset;
   logic          enable;
   logic [CW-1:0] cfg_half_period;
   logic          cfg_valid;
   logic          cfg_ready;
   logic          output_clock;
   logic          rise_strobe;
   logic          fall_strobe;
   logic          running;
   logic          stable;
`ifdef SENSOR_CLOCK_PERIOD_COUNT_EN
   logic [31:0]   period_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 input_clock = ~input_clock;

   sensor_clock_controller #(
      .COUNTER_WIDTH      (CW),
      .DEFAULT_HALF_PERIOD(2),
      .STARTUP_PERIODS    (16)
   ) dut (
      .input_clock    (input_clock),
      .reset          (reset),
      .enable         (enable),
      .cfg_half_period(cfg_half_period),
      .cfg_valid      (cfg_valid),
      .cfg_ready      (cfg_ready),
      .output_clock   (output_clock),
      .rise_strobe    (rise_strobe),
      .fall_strobe    (fall_strobe),
      .running        (running),
      .stable         (stable)
`ifdef SENSOR_CLOCK_PERIOD_COUNT_EN
      ,.period_count  (period_count)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge input_clock);
      #1;
   endtask

   // sel: 0 = rise_strobe, 1 = fall_strobe, 2 = running low
   function automatic logic sel_sig(input int sel);
      case (sel)
         0:       return rise_strobe;
         1:       return fall_strobe;
         default: return !running;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int sel, input int limit);
      int n = 0;
      while (!sel_sig(sel) && n < limit) begin
         tick();
         n = n + 1;
      end
      check_val(tag, sel_sig(sel), 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset           = 1'b1;
      enable          = 1'b0;
      cfg_valid       = 1'b0;
      cfg_half_period = '0;

      // Reset state
      tick();
      tick();
      check_val("rst_clk",    output_clock, 1'b0);
      check_val("rst_rise",   rise_strobe,  1'b0);
      check_val("rst_fall",   fall_strobe,  1'b0);
      check_val("rst_run",    running,      1'b0);
      check_val("rst_stable", stable,       1'b0);
      check_val("rst_ready",  cfg_ready,    1'b1);
      reset = 1'b0;
      tick();
      check_val("idle_run", running, 1'b0);

      // Default half=2: rise 2 cycles after RUN entry, period 4
      enable = 1'b1;
      tick();
      check_val("e0_run", running, 1'b1);
      check_val("e0_clk", output_clock, 1'b0);
      tick();
      check_val("e1_clk", output_clock, 1'b0);
      tick();
      for (int j = 0; j < 64; j++) begin
         if (j > 0) tick();
         check_val("def_clk",    output_clock, ((j / 2) % 2) == 0);
         check_val("def_rise",   rise_strobe,  (j % 4) == 0);
         check_val("def_fall",   fall_strobe,  (j % 4) == 2);
         check_val("def_stable", stable,       j >= 60);
      end
`ifdef SENSOR_CLOCK_PERIOD_COUNT_EN
      check_val("def_pcount", period_count, 32'd16);
`endif

      // Reconfig to 5 while running; applied at next fall
      cfg_valid       = 1'b1;
      cfg_half_period = 8'd5;
      tick();
      check_val("rc_clk",    output_clock, 1'b1);
      check_val("rc_ready",  cfg_ready,    1'b0);
      check_val("rc_stable", stable,       1'b1);
      cfg_valid = 1'b0;
      tick();
      check_val("rc_ready2", cfg_ready, 1'b0);
      tick();
      check_val("rc_apfall",   fall_strobe, 1'b1);
      check_val("rc_apready",  cfg_ready,   1'b1);
      check_val("rc_apstable", stable,      1'b0);
      for (int k = 1; k < 16; k++) begin
         tick();
         check_val("h5_clk",  output_clock, ((k / 5) % 2) == 1);
         check_val("h5_rise", rise_strobe,  (k % 10) == 5);
         check_val("h5_fall", fall_strobe,  (k % 10) == 0);
      end

      // Stop, then zero config in IDLE
      enable = 1'b0;
      wait_for("stop5_idle", 2, 40);
      check_val("stop5_fall", fall_strobe, 1'b1);
      check_val("stop5_clk",  output_clock, 1'b0);
      tick();
      check_val("stop5_clk2", output_clock, 1'b0);
      cfg_valid       = 1'b1;
      cfg_half_period = 8'd0;
      tick();
      check_val("z_ready0", cfg_ready, 1'b0);
      cfg_valid = 1'b0;
      tick();
      check_val("z_ready1", cfg_ready, 1'b1);
      enable = 1'b1;
      tick();
      check_val("z_e0_clk", output_clock, 1'b0);
      check_val("z_e0_stable", stable, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         tick();
         check_val("h1_clk",  output_clock, (k % 2) == 1);
         check_val("h1_rise", rise_strobe,  (k % 2) == 1);
         check_val("h1_fall", fall_strobe,  (k % 2) == 0);
      end

      // Stop from a low phase at half=1: one more high pulse, then idle
      enable = 1'b0;
      tick();
      check_val("s1_run",  running,      1'b1);
      check_val("s1_clk",  output_clock, 1'b1);
      check_val("s1_rise", rise_strobe,  1'b1);
      tick();
      check_val("s1_run2", running,      1'b0);
      check_val("s1_clk2", output_clock, 1'b0);
      check_val("s1_fall", fall_strobe,  1'b1);

      // Half=4, clean stop mid high phase
      cfg_valid       = 1'b1;
      cfg_half_period = 8'd4;
      tick();
      cfg_valid = 1'b0;
      tick();
      enable = 1'b1;
      tick();
      for (int k = 1; k <= 3; k++) begin
         tick();
         check_val("h4_lead", output_clock, 1'b0);
      end
      tick();
      check_val("h4_rise", rise_strobe, 1'b1);
      tick();
      enable = 1'b0;
      tick();
      check_val("cs_clk1", output_clock, 1'b1);
      check_val("cs_run1", running,      1'b1);
      tick();
      check_val("cs_clk2", output_clock, 1'b1);
      check_val("cs_run2", running,      1'b1);
      tick();
      check_val("cs_clk3", output_clock, 1'b0);
      check_val("cs_run3", running,      1'b0);
      check_val("cs_fall", fall_strobe,  1'b1);
      for (int k = 0; k < 2; k++) begin
         tick();
         check_val("cs_hold_clk", output_clock, 1'b0);
         check_val("cs_hold_run", running,      1'b0);
         check_val("cs_hold_rise", rise_strobe, 1'b0);
      end

      // Stop abort within one phase at half=4
      enable = 1'b1;
      tick();
      tick();
      tick();
      tick();
      tick();
      check_val("ab_rise", rise_strobe, 1'b1);
      for (int k = 0; k <= 10; k++) begin
         if (k == 0) enable = 1'b0;
         tick();
         check_val("ab_clk",  output_clock, ((k + 1) % 8) < 4);
         check_val("ab_rise", rise_strobe,  ((k + 1) % 8) == 0);
         check_val("ab_fall", fall_strobe,  ((k + 1) % 8) == 4);
         check_val("ab_run",  running,      1'b1);
         if (k == 0) enable = 1'b1;
      end

      // Back-to-back config: 3 accepted on a fall boundary, 6 held off
      cfg_valid       = 1'b1;
      cfg_half_period = 8'd3;
      tick();
      check_val("bb_t0_fall",  fall_strobe, 1'b1);
      check_val("bb_t0_ready", cfg_ready,   1'b0);
      cfg_half_period = 8'd6;
      for (int t = 1; t <= 20; t++) begin
         tick();
         case (t)
            4: begin
               check_val("bb_t4_rise",  rise_strobe, 1'b1);
               check_val("bb_t4_ready", cfg_ready,   1'b0);
            end
            8: begin
               check_val("bb_t8_fall",  fall_strobe, 1'b1);
               check_val("bb_t8_ready", cfg_ready,   1'b1);
            end
            9: begin
               check_val("bb_t9_ready", cfg_ready, 1'b0);
               cfg_valid = 1'b0;
            end
            10: check_val("bb_t10_clk", output_clock, 1'b0);
            11: check_val("bb_t11_rise", rise_strobe, 1'b1);
            14: begin
               check_val("bb_t14_fall",  fall_strobe, 1'b1);
               check_val("bb_t14_ready", cfg_ready,   1'b1);
            end
            19: begin
               check_val("bb_t19_clk",  output_clock, 1'b0);
               check_val("bb_t19_rise", rise_strobe,  1'b0);
            end
            20: check_val("bb_t20_rise", rise_strobe, 1'b1);
            default: ;
         endcase
      end

      // Reset mid-run while high at half=3, with a config pending
      cfg_valid       = 1'b1;
      cfg_half_period = 8'd3;
      tick();
      cfg_valid = 1'b0;
      wait_for("mr_fall", 1, 20);
      wait_for("mr_rise", 0, 20);
      cfg_valid       = 1'b1;
      cfg_half_period = 8'd7;
      tick();
      check_val("mr_clk",   output_clock, 1'b1);
      check_val("mr_ready", cfg_ready,    1'b0);
      cfg_valid = 1'b0;
      reset     = 1'b1;
      tick();
      check_val("mr_rst_clk",    output_clock, 1'b0);
      check_val("mr_rst_run",    running,      1'b0);
      check_val("mr_rst_ready",  cfg_ready,    1'b1);
      check_val("mr_rst_rise",   rise_strobe,  1'b0);
      check_val("mr_rst_fall",   fall_strobe,  1'b0);
      check_val("mr_rst_stable", stable,       1'b0);
`ifdef SENSOR_CLOCK_PERIOD_COUNT_EN
      check_val("mr_rst_pcount", period_count, 32'd0);
`endif
      reset = 1'b0;
      tick();
      check_val("pr_e0_run", running,      1'b1);
      check_val("pr_e0_clk", output_clock, 1'b0);
      tick();
      check_val("pr_e1_clk", output_clock, 1'b0);
      tick();
      check_val("pr_e2_clk",  output_clock, 1'b1);
      check_val("pr_e2_rise", rise_strobe,  1'b1);
`ifdef SENSOR_CLOCK_PERIOD_COUNT_EN
      check_val("pr_pcount", period_count, 32'd1);
`endif
      tick();
      check_val("pr_e3_clk", output_clock, 1'b1);
      tick();
      check_val("pr_e4_clk",  output_clock, 1'b0);
      check_val("pr_e4_fall", fall_strobe,  1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
